uart_rx_oversample: RTL and testbench

Parametrised UART serial receiver for the 16750-class UART datapath. It replaces the fixed 16× / 8-bit receiver with configurable oversampling, word length up to MAX_DATA bits, and one or two stop bits. It uses majority-vote mid-bit sampling and a valid/acknowledge handshake with overrun detection toward the RX FIFO. It sits between the baud generator (RXCLK enable) and the RX FIFO write port.

---
 rtl/uart_rx_oversample.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: majority-vote mid-bit sampling, 5..MAX_DATA data bits, optional parity, 1/2 stop bits, valid/ack handshake.
// Optional character timeout is compiled in with `define UART_RX_TIMEOUT_EN; otherwise TIMEOUT is tied low.
module uart_rx_oversample #(
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned MAX_DATA     = 9,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RXCLK,
  input  logic                RXCLEAR,
  input  logic [3:0]          WLEN,
  input  logic                PEN,
  input  logic                EPS,
  input  logic                SP,
  input  logic                STB2,
  input  logic                SIN,
  input  logic                RXACK,
  output logic [MAX_DATA-1:0] DOUT,
  output logic                PE,
  output logic                FE,
  output logic                BI,
  output logic                RXVALID,
  output logic                OE,
  output logic                TIMEOUT
);
  localparam int unsigned   CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    MAXW     = 4'(MAX_DATA);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2, BRK} state_t;

  state_t              state_q, state_d;
  logic                sin_meta_q, sin_meta_d, sin_sync_q, sin_sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic                s0_q, s0_d, s1_q, s1_d;
  logic [MAX_DATA-1:0] shift_q, shift_d, dout_q, dout_d;
  logic                par_q, par_d, stop1_q, stop1_d;
  logic                pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
  logic                rxvalid_q, rxvalid_d, oe_q, oe_d;
  logic [3:0]          wlen_eff;
  logic                vote, decide, wrap, start_det, done;
  logic                first_stop, fe_new, bi_new, pe_new, exp_par;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned   TW   = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_BITS);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tout_q, tout_d;
`endif

  always_comb begin
    wlen_eff   = (WLEN < 4'd5) ? 4'd5 : ((WLEN > MAXW) ? MAXW : WLEN);
    vote       = (s0_q & s1_q) | (s0_q & sin_sync_q) | (s1_q & sin_sync_q);
    decide     = RXCLK && (cnt_q == CNT_S2);
    wrap       = RXCLK && (cnt_q == CNT_LAST);
    start_det  = (state_q == IDLE) && RXCLK && !sin_sync_q;
    exp_par    = SP ? ~EPS : ((^shift_q) ^ ~EPS);
    first_stop = (state_q == STOP2) ? stop1_q : vote;
    pe_new     = PEN && (exp_par != par_q);
    bi_new     = (shift_q == '0) && (!PEN || !par_q) && !first_stop;
    done       = 1'b0;
    fe_new     = 1'b0;

    sin_meta_d = SIN;
    sin_sync_d = sin_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop1_d    = stop1_q;
    dout_d     = dout_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    bi_d       = bi_q;
    rxvalid_d  = rxvalid_q;
    oe_d       = oe_q;

    if (RXCLK) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (RXCLK && cnt_q == CNT_S0) s0_d = sin_sync_q;
    if (RXCLK && cnt_q == CNT_S1) s1_d = sin_sync_q;

    case (state_q)
      IDLE: if (start_det) begin
        state_d  = START;
        cnt_d    = '0;
        bitcnt_d = '0;
        shift_d  = '0;
        par_d    = 1'b0;
      end
      START: begin
        if (decide && vote) state_d = IDLE;
        else if (wrap)      state_d = DATA;
      end
      DATA: if (decide) begin
        for (int unsigned i = 0; i < MAX_DATA; i++)
          if (bitcnt_q == 4'(i)) shift_d[i] = vote;
        if (bitcnt_q == wlen_eff - 4'd1) begin
          bitcnt_d = '0;
          state_d  = PEN ? PAR : STOP1;
        end else begin
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      PAR: if (decide) begin
        par_d   = vote;
        state_d = STOP1;
      end
      STOP1: if (decide) begin
        stop1_d = vote;
        if (STB2) begin
          state_d = STOP2;
        end else begin
          done   = 1'b1;
          fe_new = ~vote;
        end
      end
      STOP2: if (decide) begin
        done   = 1'b1;
        fe_new = ~stop1_q | ~vote;
      end
      BRK: if (RXCLK && sin_sync_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (done) state_d = bi_new ? BRK : IDLE;

    // A completing frame may replace the held one only if the slot is free or being acked this cycle.
    if (done) begin
      if (!rxvalid_q || RXACK) begin
        dout_d    = shift_q;
        pe_d      = pe_new;
        fe_d      = fe_new;
        bi_d      = bi_new;
        rxvalid_d = 1'b1;
        oe_d      = 1'b0;
      end else begin
        oe_d = 1'b1;
      end
    end else if (RXACK && rxvalid_q) begin
      rxvalid_d = 1'b0;
      oe_d      = 1'b0;
    end

`ifdef UART_RX_TIMEOUT_EN
    tcnt_d = tcnt_q;
    tout_d = tout_q;
    if (start_det || RXACK) begin
      tcnt_d = '0;
      tout_d = 1'b0;
    end else if (state_q == IDLE && rxvalid_q && wrap && !tout_q) begin
      tcnt_d = tcnt_q + TW'(1);
      if (tcnt_d == TMAX) tout_d = 1'b1;
    end
`endif

    if (RXCLEAR) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bitcnt_d  = '0;
      s0_d      = 1'b0;
      s1_d      = 1'b0;
      shift_d   = '0;
      par_d     = 1'b0;
      stop1_d   = 1'b0;
      dout_d    = '0;
      pe_d      = 1'b0;
      fe_d      = 1'b0;
      bi_d      = 1'b0;
      rxvalid_d = 1'b0;
      oe_d      = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      tcnt_d    = '0;
      tout_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sin_meta_q <= 1'b1;
      sin_sync_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop1_q    <= 1'b0;
      dout_q     <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bi_q       <= 1'b0;
      rxvalid_q  <= 1'b0;
      oe_q       <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      tcnt_q     <= '0;
      tout_q     <= 1'b0;
`endif
    end else begin
      sin_meta_q <= sin_meta_d;
      sin_sync_q <= sin_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop1_q    <= stop1_d;
      dout_q     <= dout_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      bi_q       <= bi_d;
      rxvalid_q  <= rxvalid_d;
      oe_q       <= oe_d;
`ifdef UART_RX_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      tout_q     <= tout_d;
`endif
    end
  end

  assign DOUT    = dout_q;
  assign PE      = pe_q;
  assign FE      = fe_q;
  assign BI      = bi_q;
  assign RXVALID = rxvalid_q;
  assign OE      = oe_q;
`ifdef UART_RX_TIMEOUT_EN
  assign TIMEOUT = tout_q;
`else
  // TIMEOUT_BITS only matters when the timeout counter is built.
  logic timeout_bits_unused;
  assign timeout_bits_unused = (TIMEOUT_BITS != 0);
  assign TIMEOUT = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed self-checking bench for uart_rx_oversample: frames, parity, stop bits, break, glitch, overrun, clear, reset, timeout.
module tb_uart_rx_oversample;
  localparam int unsigned OS       = 16;
  localparam int unsigned MD       = 9;
  localparam int unsigned TO_BITS  = 40;
  localparam int unsigned DIV      = 4;
  localparam int unsigned BIT_CLKS = OS * DIV;

  logic          CLK = 1'b0;
  logic          RXCLK = 1'b0;
  logic          RST, RXCLEAR, PEN, EPS, SP, STB2, SIN, RXACK;
  logic [3:0]    WLEN;
  logic [MD-1:0] DOUT;
  logic          PE, FE, BI, RXVALID, OE, TIMEOUT;
  int            checks = 0;
  int            failures = 0;
  int unsigned   div_cnt = 0;

  uart_rx_oversample #(.OVERSAMPLE(OS), .MAX_DATA(MD), .TIMEOUT_BITS(TO_BITS)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR), .WLEN(WLEN),
    .PEN(PEN), .EPS(EPS), .SP(SP), .STB2(STB2), .SIN(SIN), .RXACK(RXACK),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .RXVALID(RXVALID), .OE(OE), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    RXCLK = (div_cnt == DIV - 1);
    div_cnt = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
  end

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_bits(input int unsigned n);
    wait_clks(n * BIT_CLKS);
  endtask

  task automatic send_frame(input logic [8:0] data, input int unsigned nbits, input logic with_par,
                            input logic par_bit, input logic stop1, input logic two_stop, input logic stop2);
    SIN = 1'b0;
    wait_bits(1);
    for (int unsigned i = 0; i < nbits; i++) begin
      SIN = data[i];
      wait_bits(1);
    end
    if (with_par) begin
      SIN = par_bit;
      wait_bits(1);
    end
    SIN = stop1;
    wait_bits(1);
    if (two_stop) begin
      SIN = stop2;
      wait_bits(1);
    end
    SIN = 1'b1;
  endtask

  task automatic do_ack();
    RXACK = 1'b1;
    @(negedge CLK);
    RXACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; RXCLEAR = 1'b0; WLEN = 4'd8; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    STB2 = 1'b0; SIN = 1'b1; RXACK = 1'b0;
    wait_clks(3);
    checks++;
    if ({DOUT, PE, FE, BI, RXVALID, OE, TIMEOUT} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {DOUT, PE, FE, BI, RXVALID, OE, TIMEOUT});
    end
    RST = 1'b0;
    wait_bits(2);
    checks++;
    if ({DOUT, PE, FE, BI, RXVALID, OE, TIMEOUT} !== '0) begin
      failures++; $display("FAIL post_reset_idle got=%h exp=0", {DOUT, PE, FE, BI, RXVALID, OE, TIMEOUT});
    end
  endtask

  task automatic test_basic();
    WLEN = 4'd8; PEN = 1'b0; STB2 = 1'b0;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (RXVALID !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", RXVALID); end
    checks++;
    if (DOUT !== 9'h0A5) begin failures++; $display("FAIL basic_dout got=%h exp=0a5", DOUT); end
    checks++;
    if ({PE, FE, BI, OE} !== 4'b0000) begin failures++; $display("FAIL basic_flags got=%b exp=0000", {PE, FE, BI, OE}); end
    do_ack();
    checks++;
    if (RXVALID !== 1'b0) begin failures++; $display("FAIL basic_ack_valid got=%b exp=0", RXVALID); end
    checks++;
    if (DOUT !== 9'h0A5) begin failures++; $display("FAIL basic_ack_hold got=%h exp=0a5", DOUT); end
    wait_bits(1);
  endtask

  task automatic test_parity();
    WLEN = 4'd7; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
    // 0x35 (7 bits) has four ones, so even parity bit is 0
    send_frame(9'h035, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (DOUT !== 9'h035) begin failures++; $display("FAIL par_bad_dout got=%h exp=035", DOUT); end
    checks++;
    if ({RXVALID, PE} !== 2'b11) begin failures++; $display("FAIL par_bad_pe got=%b exp=11", {RXVALID, PE}); end
    do_ack();
    wait_bits(1);
    send_frame(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, PE, FE} !== 3'b100 || DOUT !== 9'h035) begin
      failures++; $display("FAIL par_good got=%b/%h exp=100/035", {RXVALID, PE, FE}, DOUT);
    end
    do_ack();
    wait_bits(1);
    SP = 1'b1; EPS = 1'b0;
    send_frame(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, PE} !== 2'b11) begin failures++; $display("FAIL par_stick got=%b exp=11", {RXVALID, PE}); end
    do_ack();
    SP = 1'b0; PEN = 1'b0;
    wait_bits(1);
  endtask

  task automatic test_wlen_clamp();
    WLEN = 4'hF;
    send_frame(9'h1A5, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (DOUT !== 9'h1A5) begin failures++; $display("FAIL wlen_max got=%h exp=1a5", DOUT); end
    do_ack();
    wait_bits(1);
    WLEN = 4'd3;
    send_frame(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, DOUT} !== {1'b1, 9'h015}) begin failures++; $display("FAIL wlen_min got=%b/%h exp=1/015", RXVALID, DOUT); end
    do_ack();
    WLEN = 4'd8;
    wait_bits(1);
  endtask

  task automatic test_two_stop();
    STB2 = 1'b1;
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({RXVALID, FE, BI} !== 3'b110 || DOUT !== 9'h03C) begin
      failures++; $display("FAIL stop2_bad got=%b/%h exp=110/03c", {RXVALID, FE, BI}, DOUT);
    end
    do_ack();
    wait_bits(2);
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({RXVALID, FE, OE} !== 3'b100 || DOUT !== 9'h0C3) begin
      failures++; $display("FAIL stop2_good got=%b/%h exp=100/0c3", {RXVALID, FE, OE}, DOUT);
    end
    do_ack();
    STB2 = 1'b0;
    wait_bits(1);
  endtask

  task automatic test_break();
    SIN = 1'b0;
    wait_bits(12);
    checks++;
    if ({RXVALID, BI, FE, PE} !== 4'b1110 || DOUT !== 9'h000) begin
      failures++; $display("FAIL break_flags got=%b/%h exp=1110/000", {RXVALID, BI, FE, PE}, DOUT);
    end
    do_ack();
    wait_bits(3);
    checks++;
    if (RXVALID !== 1'b0) begin failures++; $display("FAIL break_hold got=%b exp=0", RXVALID); end
    SIN = 1'b1;
    wait_bits(2);
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, BI, FE} !== 3'b100 || DOUT !== 9'h05A) begin
      failures++; $display("FAIL break_recover got=%b/%h exp=100/05a", {RXVALID, BI, FE}, DOUT);
    end
    do_ack();
    wait_bits(1);
  endtask

  task automatic test_glitch();
    SIN = 1'b0;
    wait_clks(4 * DIV);
    SIN = 1'b1;
    wait_bits(3);
    checks++;
    if (RXVALID !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", RXVALID); end
    send_frame(9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, DOUT} !== {1'b1, 9'h096}) begin failures++; $display("FAIL glitch_next got=%b/%h exp=1/096", RXVALID, DOUT); end
    do_ack();
    wait_bits(1);
  endtask

  task automatic test_back_to_back();
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, OE} !== 2'b11) begin failures++; $display("FAIL overrun_oe got=%b exp=11", {RXVALID, OE}); end
    checks++;
    if (DOUT !== 9'h011) begin failures++; $display("FAIL overrun_dout got=%h exp=011", DOUT); end
    do_ack();
    checks++;
    if ({RXVALID, OE} !== 2'b00) begin failures++; $display("FAIL overrun_ack got=%b exp=00", {RXVALID, OE}); end
    wait_bits(1);
  endtask

  task automatic test_clear();
    send_frame(9'h044, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    SIN = 1'b0;
    wait_bits(3);
    RXCLEAR = 1'b1; SIN = 1'b1;
    @(negedge CLK);
    RXCLEAR = 1'b0;
    checks++;
    if ({RXVALID, OE, PE, FE, BI, DOUT} !== '0) begin
      failures++; $display("FAIL clear_outputs got=%h exp=0", {RXVALID, OE, PE, FE, BI, DOUT});
    end
    wait_bits(12);
    checks++;
    if (RXVALID !== 1'b0) begin failures++; $display("FAIL clear_no_frame got=%b exp=0", RXVALID); end
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, DOUT} !== {1'b1, 9'h081}) begin failures++; $display("FAIL clear_next got=%b/%h exp=1/081", RXVALID, DOUT); end
    do_ack();
    wait_bits(1);
  endtask

  task automatic test_rst_mid();
    send_frame(9'h07E, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    SIN = 1'b0;
    wait_bits(1);
    SIN = 1'b1;
    wait_bits(2);
    RST = 1'b1;
    wait_clks(2);
    checks++;
    if ({DOUT, PE, FE, BI, RXVALID, OE, TIMEOUT} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", {DOUT, PE, FE, BI, RXVALID, OE, TIMEOUT});
    end
    RST = 1'b0;
    wait_bits(12);
    checks++;
    if ({RXVALID, DOUT} !== '0) begin failures++; $display("FAIL rst_mid_no_frame got=%b/%h exp=0/000", RXVALID, DOUT); end
  endtask

  task automatic test_timeout();
    send_frame(9'h05C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({RXVALID, TIMEOUT} !== 2'b10) begin failures++; $display("FAIL tmo_start got=%b exp=10", {RXVALID, TIMEOUT}); end
`ifdef UART_RX_TIMEOUT_EN
    wait_bits(TO_BITS - 2);
    checks++;
    if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", TIMEOUT); end
    wait_bits(3);
    checks++;
    if (TIMEOUT !== 1'b1) begin failures++; $display("FAIL tmo_fire got=%b exp=1", TIMEOUT); end
    do_ack();
    checks++;
    if ({RXVALID, TIMEOUT} !== 2'b00) begin failures++; $display("FAIL tmo_ack got=%b exp=00", {RXVALID, TIMEOUT}); end
`else
    wait_bits(TO_BITS + 1);
    checks++;
    if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL tmo_disabled got=%b exp=0", TIMEOUT); end
    do_ack();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_wlen_clamp();
    test_two_stop();
    test_break();
    test_glitch();
    test_back_to_back();
    test_clear();
    test_timeout();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
